// File: rtl/alu_sweep_ctrl.sv
// Sweep controller for a 16-bit ALU. It latches one operand set, steps the opcode through 0..7,
// captures each result into an 8-entry table, and counts the negative and zero flags.
module alu_sweep_ctrl #(
  parameter int WIDTH       = 16,
  parameter int HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             carry_in,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_opcode,
  output logic             alu_carry,
  input  logic [WIDTH-1:0] alu_w,
  input  logic             alu_neg,
  input  logic             alu_zer,
  output logic             busy,
  output logic             done,
  input  logic [2:0]       rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_neg,
  output logic             rd_zer,
  output logic [3:0]       neg_count,
  output logic [3:0]       zero_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [2:0] OP_LAST  = 3'd7;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       cnt;
  logic             capture;
  logic [WIDTH-1:0] tbl_w [8];
  logic [7:0]       tbl_neg;
  logic [7:0]       tbl_zer;

  // Counts peak at 8 and fit in 4 bits, so no saturation is needed.
  function automatic logic [3:0] count_add(input logic [3:0] c, input logic flag);
    return c + {3'd0, flag};
  endfunction

  // A capture happens on the last clock of each opcode hold.
  assign capture = (state == RUN) && (cnt >= CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (capture && (alu_opcode == OP_LAST)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand and opcode drive, hold counter, and flag counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_carry  <= 1'b0;
      alu_opcode <= 3'd0;
      cnt        <= 8'd0;
      neg_count  <= 4'd0;
      zero_count <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            alu_a      <= a_in;
            alu_b      <= b_in;
            alu_carry  <= carry_in;
            alu_opcode <= 3'd0;
            cnt        <= 8'd0;
            neg_count  <= 4'd0;
            zero_count <= 4'd0;
          end
        end
        RUN: begin
          if (!capture) begin
            cnt <= cnt + 8'd1;
          end else begin
            cnt        <= 8'd0;
            neg_count  <= count_add(neg_count, alu_neg);
            zero_count <= count_add(zero_count, alu_zer);
            if (alu_opcode != OP_LAST) begin
              alu_opcode <= alu_opcode + 3'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // The result table is overwritten entry by entry and is never cleared by start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        tbl_w[i] <= '0;
      end
      tbl_neg <= 8'd0;
      tbl_zer <= 8'd0;
    end else if (capture) begin
      tbl_w[alu_opcode]   <= alu_w;
      tbl_neg[alu_opcode] <= alu_neg;
      tbl_zer[alu_opcode] <= alu_zer;
    end
  end

  assign rd_data = tbl_w[rd_addr];
  assign rd_neg  = tbl_neg[rd_addr];
  assign rd_zer  = tbl_zer[rd_addr];

endmodule

// File: tb/tb_alu_sweep_ctrl.sv
// Directed bench for alu_sweep_ctrl: a HOLD_CYCLES=4 instance and a HOLD_CYCLES=1 instance,
// each connected to a small ALU model where the result is opcode-3.
module tb_alu_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
    logic        neg;
    logic        zer;
  } vec_t;
  vec_t tbl [8];

  // HOLD_CYCLES = 4 instance
  logic        rst4, start4, c4, alu_c4, n4, z4, busy4, done4, rn4, rz4;
  logic [15:0] a4, b4, alu_a4, alu_b4, w4, rd4;
  logic [2:0]  op4, ra4;
  logic [3:0]  nc4, zc4;

  assign w4 = {13'd0, op4} - 16'd3;
  assign n4 = w4[15];
  assign z4 = (w4 == 16'd0);

  alu_sweep_ctrl #(.WIDTH(16), .HOLD_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .a_in(a4), .b_in(b4), .carry_in(c4),
    .alu_a(alu_a4), .alu_b(alu_b4), .alu_opcode(op4), .alu_carry(alu_c4),
    .alu_w(w4), .alu_neg(n4), .alu_zer(z4), .busy(busy4), .done(done4),
    .rd_addr(ra4), .rd_data(rd4), .rd_neg(rn4), .rd_zer(rz4),
    .neg_count(nc4), .zero_count(zc4)
  );

  // HOLD_CYCLES = 1 instance
  logic        rst1, start1, c1, alu_c1, n1, z1, busy1, done1, rn1, rz1;
  logic [15:0] a1, b1, alu_a1, alu_b1, w1, rd1;
  logic [2:0]  op1, ra1;
  logic [3:0]  nc1, zc1;

  assign w1 = {13'd0, op1} - 16'd3;
  assign n1 = w1[15];
  assign z1 = (w1 == 16'd0);

  alu_sweep_ctrl #(.WIDTH(16), .HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .a_in(a1), .b_in(b1), .carry_in(c1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_opcode(op1), .alu_carry(alu_c1),
    .alu_w(w1), .alu_neg(n1), .alu_zer(z1), .busy(busy1), .done(done1),
    .rd_addr(ra1), .rd_data(rd1), .rd_neg(rn1), .rd_zer(rz1),
    .neg_count(nc1), .zero_count(zc1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_table4();
    for (int i = 0; i < 8; i++) begin
      ra4 = tbl[i].addr;
      #1;
      check($sformatf("h4_rd_data[%0d]", i), {16'd0, rd4}, {16'd0, tbl[i].data});
      check($sformatf("h4_rd_neg[%0d]", i), {31'd0, rn4}, {31'd0, tbl[i].neg});
      check($sformatf("h4_rd_zer[%0d]", i), {31'd0, rz4}, {31'd0, tbl[i].zer});
    end
    check("h4_neg_count", {28'd0, nc4}, 32'd3);
    check("h4_zero_count", {28'd0, zc4}, 32'd1);
  endtask

  task automatic check_table1();
    for (int i = 0; i < 8; i++) begin
      ra1 = tbl[i].addr;
      #1;
      check($sformatf("h1_rd_data[%0d]", i), {16'd0, rd1}, {16'd0, tbl[i].data});
      check($sformatf("h1_rd_neg[%0d]", i), {31'd0, rn1}, {31'd0, tbl[i].neg});
      check($sformatf("h1_rd_zer[%0d]", i), {31'd0, rz1}, {31'd0, tbl[i].zer});
    end
    check("h1_neg_count", {28'd0, nc1}, 32'd3);
    check("h1_zero_count", {28'd0, zc1}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int done_hi;

    tbl[0] = '{3'd0, 16'hFFFD, 1'b1, 1'b0};
    tbl[1] = '{3'd1, 16'hFFFE, 1'b1, 1'b0};
    tbl[2] = '{3'd2, 16'hFFFF, 1'b1, 1'b0};
    tbl[3] = '{3'd3, 16'h0000, 1'b0, 1'b1};
    tbl[4] = '{3'd4, 16'h0001, 1'b0, 1'b0};
    tbl[5] = '{3'd5, 16'h0002, 1'b0, 1'b0};
    tbl[6] = '{3'd6, 16'h0003, 1'b0, 1'b0};
    tbl[7] = '{3'd7, 16'h0004, 1'b0, 1'b0};

    // Reset held for two cycles while start is high
    rst4 = 1'b1; start4 = 1'b1; a4 = 16'hAAAA; b4 = 16'h5555; c4 = 1'b1; ra4 = 3'd0;
    rst1 = 1'b1; start1 = 1'b1; a1 = 16'hAAAA; b1 = 16'h5555; c1 = 1'b1; ra1 = 3'd0;
    repeat (2) tick();
    check("rst_alu_a", {16'd0, alu_a4}, 32'd0);
    check("rst_alu_b", {16'd0, alu_b4}, 32'd0);
    check("rst_alu_carry", {31'd0, alu_c4}, 32'd0);
    check("rst_opcode", {29'd0, op4}, 32'd0);
    check("rst_busy", {31'd0, busy4}, 32'd0);
    check("rst_done", {31'd0, done4}, 32'd0);
    check("rst_neg_count", {28'd0, nc4}, 32'd0);
    check("rst_zero_count", {28'd0, zc4}, 32'd0);
    check("rst_rd_data", {16'd0, rd4}, 32'd0);
    check("rst_busy_h1", {31'd0, busy1}, 32'd0);
    start4 = 1'b0; start1 = 1'b0; rst4 = 1'b0; rst1 = 1'b0;
    tick();
    check("idle_no_start_busy", {31'd0, busy4}, 32'd0);

    // Basic sweep with a start attempt in the middle of RUN
    a4 = 16'h1234; b4 = 16'h8001; c4 = 1'b1; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    check("start_alu_a", {16'd0, alu_a4}, 32'h1234);
    check("start_alu_b", {16'd0, alu_b4}, 32'h8001);
    check("start_alu_carry", {31'd0, alu_c4}, 32'd1);
    check("start_busy", {31'd0, busy4}, 32'd1);
    check("start_opcode", {29'd0, op4}, 32'd0);
    for (int n = 1; n <= 33; n++) begin
      if (n == 10) begin
        start4 = 1'b1; a4 = 16'hDEAD;
      end else begin
        start4 = 1'b0;
      end
      tick();
      check($sformatf("sweep_opcode@%0d", n), {29'd0, op4}, (n >= 32) ? 32'd7 : 32'(n / 4));
      check($sformatf("sweep_busy@%0d", n), {31'd0, busy4}, (n < 32) ? 32'd1 : 32'd0);
      check($sformatf("sweep_done@%0d", n), {31'd0, done4}, (n == 32) ? 32'd1 : 32'd0);
      check($sformatf("sweep_alu_a@%0d", n), {16'd0, alu_a4}, 32'h1234);
    end
    check_table4();

    // Second sweep interrupted by reset while opcode 5 is driven
    @(negedge clk);
    a4 = 16'h0F0F; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    check("restart_neg_count_clear", {28'd0, nc4}, 32'd0);
    check("restart_zero_count_clear", {28'd0, zc4}, 32'd0);
    ra4 = 3'd7;
    #1;
    check("old_entry7_held", {16'd0, rd4}, 32'h0004);
    @(negedge clk);
    repeat (19) tick();
    check("mid_opcode5", {29'd0, op4}, 32'd5);
    rst4 = 1'b1;
    #1;
    check("midrst_opcode", {29'd0, op4}, 32'd0);
    check("midrst_alu_a", {16'd0, alu_a4}, 32'd0);
    check("midrst_busy", {31'd0, busy4}, 32'd0);
    check("midrst_neg_count", {28'd0, nc4}, 32'd0);
    ra4 = 3'd7;
    #1;
    check("midrst_entry7_cleared", {16'd0, rd4}, 32'd0);
    ra4 = 3'd0;
    #1;
    check("midrst_entry0_cleared", {16'd0, rd4}, 32'd0);
    @(negedge clk);
    tick();
    rst4 = 1'b0;
    done_hi = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (done4 || busy4) done_hi++;
    end
    check("midrst_no_done_or_busy", 32'(done_hi), 32'd0);

    // Clean sweep after the reset
    a4 = 16'h1234; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (k = 0; k < 100 && !done4; k++) tick();
    check("clean_done_seen", {31'd0, done4}, 32'd1);
    check("clean_done_latency", 32'(k), 32'd32);
    tick();
    check_table4();

    // HOLD_CYCLES=1 with start held high across two sweeps
    @(negedge clk);
    a1 = 16'h1234; b1 = 16'h8001; c1 = 1'b1; start1 = 1'b1;
    for (int n = 0; n <= 10; n++) begin
      tick();
      check($sformatf("h1_busy@%0d", n), {31'd0, busy1}, (n < 8 || n == 10) ? 32'd1 : 32'd0);
      check($sformatf("h1_done@%0d", n), {31'd0, done1}, (n == 8) ? 32'd1 : 32'd0);
      check($sformatf("h1_opcode@%0d", n), {29'd0, op1},
            (n < 8) ? 32'(n) : ((n == 10) ? 32'd0 : 32'd7));
    end
    start1 = 1'b0;
    for (k = 0; k < 50 && !done1; k++) tick();
    check("h1_second_done_latency", 32'(k), 32'd8);
    tick();
    check_table1();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
